// File: rtl/spi_pkg.sv
// spi_pkg: shared constants for the SPI master serial data path
package spi_pkg;
    localparam int SPI_DATA_W = 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_XFER = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;
endpackage

// File: rtl/spi_shifter.sv
// spi_shifter: SPI master shift path, drives mosi and assembles the received word
module spi_shifter
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic              ss_i,
    input  logic              send_data_i,
    input  logic              lsbfe_i,
    input  logic              cpol_i,
    input  logic              cpha_i,
    input  logic              mosi_s_sclk_i,
    input  logic              mosi_s_sclk0_i,
    input  logic              miso_r_sclk_i,
    input  logic              miso_r_sclk0_i,
    input  logic [DATA_W-1:0] data_mosi_i,
    input  logic              miso_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] data_miso_o,
    output logic              rx_done_o,
    output logic              busy_o
);
    localparam int CW = $clog2(DATA_W + 1);
    localparam int IW = $clog2(DATA_W);

    logic [1:0]        state;
    logic [DATA_W-1:0] tx_sh;
    logic [DATA_W-1:0] rx_sh;
    logic [CW-1:0]     tx_cnt;
    logic [CW-1:0]     rx_cnt;
    logic              lsb_q;
    logic              cpha_q;
    logic              cpol_q;
    logic              tx_stb;
    logic              rx_stb;

    function automatic logic [IW-1:0] idx(input logic [CW-1:0] k, input logic lsb);
        return lsb ? k[IW-1:0] : IW'(DATA_W - 1) - k[IW-1:0];
    endfunction

    assign tx_stb = (cpol_q ^ cpha_q) ? mosi_s_sclk0_i : mosi_s_sclk_i;
    assign rx_stb = (cpol_q ^ cpha_q) ? miso_r_sclk0_i : miso_r_sclk_i;
    assign busy_o = state != ST_IDLE;

    // transfer sequencing: latch config, shift bits out/in, publish the received word
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state       <= ST_IDLE;
            tx_sh       <= '0;
            rx_sh       <= '0;
            tx_cnt      <= '0;
            rx_cnt      <= '0;
            lsb_q       <= 1'b0;
            cpha_q      <= 1'b0;
            cpol_q      <= 1'b0;
            mosi_o      <= 1'b0;
            data_miso_o <= '0;
            rx_done_o   <= 1'b0;
        end else begin
            rx_done_o <= 1'b0;
            case (state)
                ST_IDLE: if (send_data_i) begin
                    tx_sh  <= data_mosi_i;
                    lsb_q  <= lsbfe_i;
                    cpha_q <= cpha_i;
                    cpol_q <= cpol_i;
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                    state  <= ST_LOAD;
                end
                ST_LOAD: if (ss_i) begin
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                    state  <= ST_IDLE;
                end else begin
                    if (!cpha_q) begin
                        mosi_o <= tx_sh[idx('0, lsb_q)];
                        tx_cnt <= CW'(1);
                    end
                    state <= ST_XFER;
                end
                ST_XFER: if (ss_i) begin
                    tx_cnt <= '0;
                    rx_cnt <= '0;
                    state  <= ST_IDLE;
                end else begin
                    if (tx_stb && tx_cnt < CW'(DATA_W)) begin
                        mosi_o <= tx_sh[idx(tx_cnt, lsb_q)];
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                    if (rx_stb) begin
                        rx_sh[idx(rx_cnt, lsb_q)] <= miso_i;
                        rx_cnt <= rx_cnt + 1'b1;
                        if (rx_cnt == CW'(DATA_W - 1)) state <= ST_DONE;
                    end
                end
                default: begin
                    data_miso_o <= rx_sh;
                    rx_done_o   <= 1'b1;
                    state       <= ST_IDLE;
                end
            endcase
        end
    end
endmodule
